frame_buffer_scheduler: RTL and testbench
=========================================

// Module: frame_buffer_scheduler
// PURPOSE
//  Ping-pong frame-buffer scheduler between the DVI pixel source and the frame consumer (encoder/USB).
//  - Captures one frame per vsync window into one of two buffers.
//  - Publishes complete frames and grants the newest one to the consumer.
//  - Never writes a buffer that is currently granted to the consumer; newest-frame-wins policy.
// PARAMETERS
//  H_ACTIVE   1024  active pixels per line
//  V_ACTIVE   768   active lines per frame
//  PIX_W      20    pixel-index width; must satisfy 2**PIX_W >= H_ACTIVE*V_ACTIVE
//  CNT_W      8     width of the saturating drop/error counters
// PORTS
//  clk          in   1        pixel clock; all logic on its rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  capture_en   in   1        sampled at frame start; low = skip that frame
//  vsync        in   1        source vsync; high = frame window
//  rgb_de       in   1        active-pixel strobe
//  rgb          in   24       pixel data
//  wr_en        out  1        buffer write strobe
//  wr_addr      out  PIX_W+1  {buffer, pixel index}
//  wr_data      out  24       pixel data to the buffer
//  rd_req       in   1        level; consumer wants a frame
//  rd_grant     out  1        consumer owns buffer rd_buf
//  rd_buf       out  1        granted buffer index
//  rd_done      in   1        1-cycle pulse; consumer finished, releases buffer
//  frame_ready  out  2        per-buffer "complete, unread" flags
//  drop_cnt     out  CNT_W    unread frames overwritten (saturating)
//  err_cnt      out  CNT_W    frames with wrong pixel count (saturating)
// BEHAVIOUR
//  Reset (async):
//   - wr_en=0, wr_addr=0, wr_data=0, rd_grant=0, rd_buf=0.
//   - frame_ready=0, drop_cnt=0, err_cnt=0.
//   - Writer FSM in W_IDLE, reader FSM in R_IDLE, vsync edge register=0.
//  Edges: vsync is registered once; rise = frame start, fall = frame end.
//  Writer FSM W_IDLE -> W_CAPT -> W_IDLE:
//   - W_IDLE + rise + capture_en=1 -> W_CAPT.
//     - Target buffer is the buffer other than the last one written, unless that one equals rd_buf
//       while rd_grant=1; then the last-written buffer is reused.
//     - frame_ready[target] cleared; drop_cnt++ if it was set.
//     - pix_cnt=0.
//   - W_IDLE + rise + capture_en=0: stays idle; the frame is ignored.
//   - W_CAPT, each rgb_de cycle with pix_cnt < H_ACTIVE*V_ACTIVE:
//     - wr_en=1, wr_addr={target, pix_cnt}, wr_data=rgb, all registered (1-cycle latency).
//     - pix_cnt++.
//   - W_CAPT, rgb_de with pix_cnt full: no write; frame flagged overrun.
//   - W_CAPT + fall -> W_IDLE.
//     - pix_cnt==H_ACTIVE*V_ACTIVE and no overrun: frame_ready[target] set next cycle.
//     - Otherwise: err_cnt++ and the buffer stays not-ready.
//   - capture_en deasserting mid-frame has no effect until the next rise.
//  Reader FSM R_IDLE <-> R_GRANT:
//   - R_IDLE + rd_req + any frame_ready bit not equal to the current write target:
//     - rd_grant=1 next cycle.
//     - rd_buf = most recently published buffer.
//   - R_GRANT held until rd_done; then frame_ready[rd_buf] cleared, rd_grant=0 next cycle, -> R_IDLE.
//     - rd_done while R_IDLE is ignored.
//   - Publish and rd_req in the same cycle: grant one cycle after the ready flag is visible (2 cycles).
//   - Frame start and grant in the same cycle: the writer evaluates rd_grant as registered,
//     so the grant targets only the non-target buffer. Writer and reader never share a buffer.
//  Counters saturate at 2**CNT_W-1.
//  rst_n low mid-frame aborts capture and grant immediately; the first capture after release needs a fresh vsync rise.
// TESTING
//  1. Small H/V (8x4); 3 clean frames, rd_req=0.
//     -> buffers 0,1,0 written; frame_ready ends 2'b11 after frame 2; drop_cnt=1 after frame 3 start.
//  2. Frame done, rd_req=1.
//     -> rd_grant=1, rd_buf=newest buffer; the next frame writes the other buffer.
//     -> rd_done pulse clears that ready bit, rd_grant=0.
//  3. Grant held on buf1 across 3 frames.
//     -> all captures go to buf0; wr_addr MSB never 1; drop_cnt +2.
//  4. Frame with 31 pixels (8x4=32 expected), then one with 33.
//     -> err_cnt=2; no ready bit set; 33rd pixel produces no wr_en.
//  5. capture_en=0 at a rise; then rst_n pulsed mid-capture.
//     -> no writes in the skipped frame; all outputs zero asynchronously on reset.
//  6. rd_req asserted with frame_ready=0.
//     -> rd_grant stays 0 until the first publish, then rises exactly 2 cycles after the vsync fall is registered.

Source files
------------

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong frame-buffer scheduler: captures vsync-framed pixels into one of two buffers and
// grants the newest complete frame to the consumer without ever sharing a buffer.
module frame_buffer_scheduler #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned PIX_W    = 20,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             capture_en,
   input  logic             vsync,
   input  logic             rgb_de,
   input  logic [23:0]      rgb,
   output logic             wr_en,
   output logic [PIX_W:0]   wr_addr,
   output logic [23:0]      wr_data,
   input  logic             rd_req,
   output logic             rd_grant,
   output logic             rd_buf,
   input  logic             rd_done,
   output logic [1:0]       frame_ready,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned     NPix   = H_ACTIVE * V_ACTIVE;
   localparam logic [PIX_W:0]  NPixC  = (PIX_W + 1)'(NPix);
   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic {WIdle, WCapt}  w_state_e;
   typedef enum logic {RIdle, RGrant} r_state_e;

   w_state_e         w_state_q, w_state_d;
   r_state_e         r_state_q, r_state_d;
   logic             vsync_q;
   logic             tgt_q, tgt_d;
   logic             last_q, last_d;
   logic             newest_q, newest_d;
   logic [PIX_W:0]   pix_cnt_q, pix_cnt_d;
   logic             ovr_q, ovr_d;
   logic             wr_en_q, wr_en_d;
   logic [PIX_W:0]   wr_addr_q, wr_addr_d;
   logic [23:0]      wr_data_q, wr_data_d;
   logic             rd_buf_q, rd_buf_d;
   logic [1:0]       frame_ready_q, frame_ready_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] err_q, err_d;

   logic       rise, fall, start, start_tgt, grant_q;
   logic       drop_inc, err_inc;
   logic [1:0] set_ready, clr_ready, rd_clr, busy, avail;

   assign rise    = vsync & ~vsync_q;
   assign fall    = ~vsync & vsync_q;
   assign grant_q = (r_state_q == RGrant);
   assign start   = (w_state_q == WIdle) & rise & capture_en;
   // Alternate buffers, but never steal the one the consumer currently holds.
   assign start_tgt = (grant_q && (~last_q == rd_buf_q)) ? last_q : ~last_q;

   always_comb begin
      w_state_d = w_state_q;
      tgt_d     = tgt_q;
      last_d    = last_q;
      newest_d  = newest_q;
      pix_cnt_d = pix_cnt_q;
      ovr_d     = ovr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      set_ready = 2'b00;
      clr_ready = 2'b00;
      drop_inc  = 1'b0;
      err_inc   = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            if (start) begin
               w_state_d            = WCapt;
               tgt_d                = start_tgt;
               last_d               = start_tgt;
               pix_cnt_d            = '0;
               ovr_d                = 1'b0;
               clr_ready[start_tgt] = 1'b1;
               drop_inc             = frame_ready_q[start_tgt];
            end
         end
         WCapt: begin
            if (fall) begin
               w_state_d = WIdle;
               if ((pix_cnt_q == NPixC) && !ovr_q) begin
                  set_ready[tgt_q] = 1'b1;
                  newest_d         = tgt_q;
               end else begin
                  err_inc = 1'b1;
               end
            end else if (rgb_de) begin
               if (pix_cnt_q < NPixC) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {tgt_q, pix_cnt_q[PIX_W-1:0]};
                  wr_data_d = rgb;
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   // A buffer being (or about to be) written is never offered to the consumer.
   always_comb begin
      busy = 2'b00;
      if (w_state_q == WCapt) begin
         busy[tgt_q] = 1'b1;
      end else if (start) begin
         busy[start_tgt] = 1'b1;
      end
   end

   assign avail = frame_ready_q & ~busy;

   always_comb begin
      r_state_d = r_state_q;
      rd_buf_d  = rd_buf_q;
      rd_clr    = 2'b00;
      unique case (r_state_q)
         RIdle: begin
            if (rd_req && (avail != 2'b00)) begin
               r_state_d = RGrant;
               rd_buf_d  = avail[newest_q] ? newest_q : ~newest_q;
            end
         end
         RGrant: begin
            if (rd_done) begin
               r_state_d        = RIdle;
               rd_clr[rd_buf_q] = 1'b1;
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_comb begin
      frame_ready_d = (frame_ready_q & ~clr_ready & ~rd_clr) | set_ready;
      drop_d        = (drop_inc && (drop_q != CntMax)) ? drop_q + 1'b1 : drop_q;
      err_d         = (err_inc && (err_q != CntMax)) ? err_q + 1'b1 : err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q     <= WIdle;
         r_state_q     <= RIdle;
         vsync_q       <= 1'b0;
         tgt_q         <= 1'b0;
         last_q        <= 1'b1;
         newest_q      <= 1'b0;
         pix_cnt_q     <= '0;
         ovr_q         <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         rd_buf_q      <= 1'b0;
         frame_ready_q <= 2'b00;
         drop_q        <= '0;
         err_q         <= '0;
      end else begin
         w_state_q     <= w_state_d;
         r_state_q     <= r_state_d;
         vsync_q       <= vsync;
         tgt_q         <= tgt_d;
         last_q        <= last_d;
         newest_q      <= newest_d;
         pix_cnt_q     <= pix_cnt_d;
         ovr_q         <= ovr_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         rd_buf_q      <= rd_buf_d;
         frame_ready_q <= frame_ready_d;
         drop_q        <= drop_d;
         err_q         <= err_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign rd_grant    = grant_q;
   assign rd_buf      = rd_buf_q;
   assign frame_ready = frame_ready_q;
   assign drop_cnt    = drop_q;
   assign err_cnt     = err_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler on a tiny 8x4 frame: buffer alternation, grants,
// pixel-count errors, skipped frames, async reset and grant latency.
module tb_frame_buffer_scheduler;

   localparam int unsigned H  = 8;
   localparam int unsigned V  = 4;
   localparam int unsigned PW = 5;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          capture_en, vsync, rgb_de, rd_req, rd_done;
   logic [23:0]   rgb;
   logic          wr_en, rd_grant, rd_buf;
   logic [PW:0]   wr_addr;
   logic [23:0]   wr_data;
   logic [1:0]    frame_ready;
   logic [CW-1:0] drop_cnt, err_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int wr_cnt0 = 0;
   int wr_cnt1 = 0;
   int data_bad = 0;
   int s0, s1;

   frame_buffer_scheduler #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .PIX_W    (PW),
      .CNT_W    (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .capture_en  (capture_en),
      .vsync       (vsync),
      .rgb_de      (rgb_de),
      .rgb         (rgb),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_req      (rd_req),
      .rd_grant    (rd_grant),
      .rd_buf      (rd_buf),
      .rd_done     (rd_done),
      .frame_ready (frame_ready),
      .drop_cnt    (drop_cnt),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   // Pixel i is sent as {A5, i}, so the written data must echo the address index.
   always @(negedge clk) begin
      if (wr_en) begin
         if (wr_addr[PW]) wr_cnt1++;
         else             wr_cnt0++;
         if (wr_data !== {8'hA5, 11'd0, wr_addr[PW-1:0]}) data_bad++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic snap();
      s0 = wr_cnt0;
      s1 = wr_cnt1;
   endtask

   // Called at a negedge; returns at the negedge right after the vsync fall was sampled.
   task automatic run_frame(input int npix, input logic cap);
      capture_en = cap;
      vsync      = 1'b1;
      @(negedge clk);
      for (int i = 0; i < npix; i++) begin
         rgb_de = 1'b1;
         rgb    = {8'hA5, 16'(i)};
         @(negedge clk);
      end
      rgb_de = 1'b0;
      @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_done();
      rd_done = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; capture_en = 1'b0; vsync = 1'b0; rgb_de = 1'b0;
      rgb = '0; rd_req = 1'b0; rd_done = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_wr_en", wr_en, 0);
      check_eq("rst_wr_addr", wr_addr, 0);
      check_eq("rst_wr_data", wr_data, 0);
      check_eq("rst_grant", rd_grant, 0);
      check_eq("rst_rd_buf", rd_buf, 0);
      check_eq("rst_ready", frame_ready, 0);
      check_eq("rst_drop", drop_cnt, 0);
      check_eq("rst_err", err_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Three clean frames, no consumer: buffers 0,1,0.
      snap(); run_frame(32, 1'b1);
      check_eq("t1_f1_buf0", wr_cnt0 - s0, 32);
      check_eq("t1_f1_buf1", wr_cnt1 - s1, 0);
      check_eq("t1_f1_ready", frame_ready, 2'b01);
      snap(); run_frame(32, 1'b1);
      check_eq("t1_f2_buf1", wr_cnt1 - s1, 32);
      check_eq("t1_f2_ready", frame_ready, 2'b11);
      snap(); run_frame(32, 1'b1);
      check_eq("t1_f3_buf0", wr_cnt0 - s0, 32);
      check_eq("t1_f3_drop", drop_cnt, 1);
      check_eq("t1_f3_ready", frame_ready, 2'b11);

      // Grant newest (buf0); next frame lands in buf1.
      rd_req = 1'b1;
      @(negedge clk);
      check_eq("t2_grant", rd_grant, 1);
      check_eq("t2_rd_buf", rd_buf, 0);
      rd_req = 1'b0;
      snap(); run_frame(32, 1'b1);
      check_eq("t2_buf1", wr_cnt1 - s1, 32);
      check_eq("t2_buf0", wr_cnt0 - s0, 0);
      check_eq("t2_drop", drop_cnt, 2);
      check_eq("t2_hold", rd_grant, 1);
      pulse_done();
      check_eq("t2_ready", frame_ready, 2'b10);
      check_eq("t2_release", rd_grant, 0);

      // Grant buf1 and hold it over three frames: all go to buf0.
      rd_req = 1'b1;
      @(negedge clk);
      check_eq("t3_grant", rd_grant, 1);
      check_eq("t3_rd_buf", rd_buf, 1);
      rd_req = 1'b0;
      snap();
      repeat (3) run_frame(32, 1'b1);
      check_eq("t3_buf1", wr_cnt1 - s1, 0);
      check_eq("t3_buf0", wr_cnt0 - s0, 96);
      check_eq("t3_drop", drop_cnt, 4);
      check_eq("t3_ready", frame_ready, 2'b11);
      pulse_done();
      check_eq("t3_ready_done", frame_ready, 2'b01);
      check_eq("t3_release", rd_grant, 0);

      // Short frame into buf1, then overlong frame into buf0.
      snap(); run_frame(31, 1'b1);
      check_eq("t4_short_wr", wr_cnt1 - s1, 31);
      check_eq("t4_short_err", err_cnt, 1);
      check_eq("t4_short_ready", frame_ready, 2'b01);
      snap(); run_frame(33, 1'b1);
      check_eq("t4_long_wr", wr_cnt0 - s0, 32);
      check_eq("t4_long_err", err_cnt, 2);
      check_eq("t4_long_ready", frame_ready, 2'b00);
      check_eq("t4_long_drop", drop_cnt, 5);

      // Skipped frame, then reset in the middle of a capture.
      snap(); run_frame(32, 1'b0);
      check_eq("t5_skip_wr", (wr_cnt0 - s0) + (wr_cnt1 - s1), 0);
      check_eq("t5_skip_err", err_cnt, 2);
      capture_en = 1'b1;
      vsync      = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         rgb_de = 1'b1;
         rgb    = {8'hA5, 16'(i)};
         @(negedge clk);
      end
      check_eq("t5_pre_wren", wr_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t5_rst_wr_en", wr_en, 0);
      check_eq("t5_rst_wr_addr", wr_addr, 0);
      check_eq("t5_rst_wr_data", wr_data, 0);
      check_eq("t5_rst_drop", drop_cnt, 0);
      check_eq("t5_rst_err", err_cnt, 0);
      check_eq("t5_rst_grant", rd_grant, 0);
      rgb_de = 1'b0;
      vsync  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Request with nothing ready; grant appears two cycles after the fall is sampled.
      rd_req = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("t6_no_grant", rd_grant, 0);
      run_frame(32, 1'b1);
      check_eq("t6_ready", frame_ready, 2'b01);
      check_eq("t6_grant_c1", rd_grant, 0);
      @(negedge clk);
      check_eq("t6_grant_c2", rd_grant, 1);
      check_eq("t6_rd_buf", rd_buf, 0);
      rd_req = 1'b0;
      pulse_done();
      check_eq("t6_release", rd_grant, 0);

      check_eq("wr_data_echo", data_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
